// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage: opcode constants,
// the alu_op encoding and the packed control bundle carried through the
// stage register.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LI    = 6'b100111;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Link register written by jal.
    localparam logic [4:0] REG_LINK = 5'd31;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_LOGIC = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_write;
        logic    mem_read;
        logic    reg_dst;
        logic    alu_src;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        logic    link;
        logic    mem_to_reg;
        alu_op_e alu_op;
        logic    zero_ext;   // immediate is zero-extended (logical immediates)
        logic    illegal;    // opcode not recognised
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control decoder.
// Ports:
//   opcode_i  in  6   instruction opcode field instr[31:26]
//   ctrl_o    out     decoded control bundle (all strobes 0 and illegal=1
//                     for unknown opcodes)
module ctrl_decode
    import decode_pkg::*;
(
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            OP_ADDI, OP_LI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_LOGIC;
                ctrl_o.zero_ext  = 1'b1;
            end
            OP_LW: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.branch_ne = 1'b1;
                ctrl_o.alu_op    = ALU_SUB;
            end
            OP_J: begin
                ctrl_o.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jump      = 1'b1;
                ctrl_o.link      = 1'b1;
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Single registered decode stage with valid/ready handshake. An accepted
// instruction word is split into its fields, its immediate extended and its
// opcode decoded; the bundle appears on the outputs the cycle after accept
// and is held until downstream takes it.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready/instr   upstream handshake and 32-bit instruction
//   out_valid/out_ready       downstream handshake for the decoded bundle
//   rs, rt, rd, shamt, funct, imm_ext, jaddr   decoded fields
//   reg_write..mem_to_reg, alu_op              control strobes
//   illegal, illegal_cnt, halted               illegal-opcode status
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int CNT_W           = 8,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [XLEN-1:0]  imm_ext,
    output logic [25:0]      jaddr,
    output logic             reg_write,
    output logic             mem_write,
    output logic             mem_read,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             branch,
    output logic             branch_ne,
    output logic             jump,
    output logic             link,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             halted
);

    function automatic logic [XLEN-1:0] ext_imm(input logic [15:0] imm, input logic zero_ext);
        if (zero_ext) begin
            return XLEN'(imm);
        end
        return XLEN'($signed(imm));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ctrl_t ctrl_dec;

    ctrl_decode u_ctrl_decode (
        .opcode_i (instr[31:26]),
        .ctrl_o   (ctrl_dec)
    );

    logic             out_valid_q, out_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             accept;

    assign in_ready = (!out_valid_q || out_ready) && !halted_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        halted_d    = halted_q;
        if (accept) begin
            // Accept wins over drain: a same-cycle accept replaces the bundle.
            out_valid_d = 1'b1;
            instr_d     = instr;
            rd_d        = ctrl_dec.link ? REG_LINK : instr[15:11];
            imm_d       = ext_imm(instr[15:0], ctrl_dec.zero_ext);
            ctrl_d      = ctrl_dec;
            if (ctrl_dec.illegal) begin
                cnt_d    = sat_inc(cnt_q);
                halted_d = HALT_ON_ILLEGAL;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = rd_q;
    assign shamt       = instr_q[10:6];
    assign funct       = instr_q[5:0];
    assign imm_ext     = imm_q;
    assign jaddr       = instr_q[25:0];
    assign reg_write   = ctrl_q.reg_write;
    assign mem_write   = ctrl_q.mem_write;
    assign mem_read    = ctrl_q.mem_read;
    assign reg_dst     = ctrl_q.reg_dst;
    assign alu_src     = ctrl_q.alu_src;
    assign branch      = ctrl_q.branch;
    assign branch_ne   = ctrl_q.branch_ne;
    assign jump        = ctrl_q.jump;
    assign link        = ctrl_q.link;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign alu_op      = ctrl_q.alu_op;
    assign illegal     = ctrl_q.illegal;
    assign illegal_cnt = cnt_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    always #5 clk = ~clk;

    // DUT A: no halting, 2-bit counter. DUT H: halts on illegal, 8-bit counter.
    logic        in_ready_a, out_valid_a;
    logic [4:0]  rs_a, rt_a, rd_a, shamt_a;
    logic [5:0]  funct_a;
    logic [31:0] imm_a;
    logic [25:0] jaddr_a;
    logic        reg_write_a, mem_write_a, mem_read_a, reg_dst_a, alu_src_a;
    logic        branch_a, branch_ne_a, jump_a, link_a, mem_to_reg_a;
    logic [1:0]  alu_op_a;
    logic        illegal_a, halted_a;
    logic [1:0]  cnt_a;

    logic        in_ready_h, out_valid_h;
    logic [4:0]  rs_h, rt_h, rd_h, shamt_h;
    logic [5:0]  funct_h;
    logic [31:0] imm_h;
    logic [25:0] jaddr_h;
    logic        reg_write_h, mem_write_h, mem_read_h, reg_dst_h, alu_src_h;
    logic        branch_h, branch_ne_h, jump_h, link_h, mem_to_reg_h;
    logic [1:0]  alu_op_h;
    logic        illegal_h, halted_h;
    logic [7:0]  cnt_h;

    wire [9:0] ctl_a = {reg_write_a, mem_write_a, mem_read_a, reg_dst_a, alu_src_a,
                        branch_a, branch_ne_a, jump_a, link_a, mem_to_reg_a};
    wire [9:0] ctl_h = {reg_write_h, mem_write_h, mem_read_h, reg_dst_h, alu_src_h,
                        branch_h, branch_ne_h, jump_h, link_h, mem_to_reg_h};

    instr_decode_stage #(.XLEN(32), .CNT_W(2), .HALT_ON_ILLEGAL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .rs(rs_a), .rt(rt_a), .rd(rd_a), .shamt(shamt_a), .funct(funct_a),
        .imm_ext(imm_a), .jaddr(jaddr_a),
        .reg_write(reg_write_a), .mem_write(mem_write_a), .mem_read(mem_read_a),
        .reg_dst(reg_dst_a), .alu_src(alu_src_a), .branch(branch_a), .branch_ne(branch_ne_a),
        .jump(jump_a), .link(link_a), .mem_to_reg(mem_to_reg_a), .alu_op(alu_op_a),
        .illegal(illegal_a), .illegal_cnt(cnt_a), .halted(halted_a)
    );

    instr_decode_stage #(.XLEN(32), .CNT_W(8), .HALT_ON_ILLEGAL(1'b1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .instr(instr),
        .out_valid(out_valid_h), .out_ready(out_ready),
        .rs(rs_h), .rt(rt_h), .rd(rd_h), .shamt(shamt_h), .funct(funct_h),
        .imm_ext(imm_h), .jaddr(jaddr_h),
        .reg_write(reg_write_h), .mem_write(mem_write_h), .mem_read(mem_read_h),
        .reg_dst(reg_dst_h), .alu_src(alu_src_h), .branch(branch_h), .branch_ne(branch_ne_h),
        .jump(jump_h), .link(link_h), .mem_to_reg(mem_to_reg_h), .alu_op(alu_op_h),
        .illegal(illegal_h), .illegal_cnt(cnt_h), .halted(halted_h)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control vector order: reg_write mem_write mem_read reg_dst alu_src
    //                       branch branch_ne jump link mem_to_reg
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [25:0] jaddr;
        logic [9:0]  ctl;
        logic [1:0]  alu;
    } vec_t;

    vec_t vecs[10];

    localparam logic [31:0] I_ADDI = 32'h2021_8000;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    initial begin
        vecs[0] = '{32'h8C22_FFFC, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3C, 32'hFFFF_FFFC, 26'h022_FFFC, 10'b1010100001, 2'b00}; // lw
        vecs[1] = '{32'h3421_8000, 5'd1, 5'd1, 5'd16, 5'd0,  6'h00, 32'h0000_8000, 26'h021_8000, 10'b1000100000, 2'b11}; // ori
        vecs[2] = '{32'h2021_8000, 5'd1, 5'd1, 5'd16, 5'd0,  6'h00, 32'hFFFF_8000, 26'h021_8000, 10'b1000100000, 2'b00}; // addi
        vecs[3] = '{32'h0043_0820, 5'd2, 5'd3, 5'd1,  5'd0,  6'h20, 32'h0000_0820, 26'h043_0820, 10'b1001000000, 2'b10}; // R add
        vecs[4] = '{32'hAC22_0004, 5'd1, 5'd2, 5'd0,  5'd0,  6'h04, 32'h0000_0004, 26'h022_0004, 10'b0100100000, 2'b00}; // sw
        vecs[5] = '{32'h1022_FFFE, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3E, 32'hFFFF_FFFE, 26'h022_FFFE, 10'b0000010000, 2'b01}; // beq
        vecs[6] = '{32'h3021_FFFF, 5'd1, 5'd1, 5'd31, 5'd31, 6'h3F, 32'h0000_FFFF, 26'h021_FFFF, 10'b1000100000, 2'b11}; // andi
        vecs[7] = '{32'h0800_0040, 5'd0, 5'd0, 5'd0,  5'd1,  6'h00, 32'h0000_0040, 26'h000_0040, 10'b0000000100, 2'b00}; // j
        vecs[8] = '{32'h0C00_0100, 5'd0, 5'd0, 5'd31, 5'd4,  6'h00, 32'h0000_0100, 26'h000_0100, 10'b1000000110, 2'b00}; // jal
        vecs[9] = '{32'h9C01_8001, 5'd0, 5'd1, 5'd16, 5'd0,  6'h01, 32'hFFFF_8001, 26'h001_8001, 10'b1000100000, 2'b00}; // li

        rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        repeat (2) tick();
        chk("rst out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst imm_ext", imm_a, 32'd0);
        chk("rst ctl", {22'd0, ctl_a}, 32'd0);
        chk("rst cnt", {30'd0, cnt_a}, 32'd0);
        chk("rst halted", {31'd0, halted_h}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready_a}, 32'd1);
        rst = 1'b0;

        // Back-to-back decode table with downstream always ready.
        for (int i = 0; i < 10; i++) begin
            instr = vecs[i].instr; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid_a}, 32'd1);
            chk($sformatf("v%0d rs", i), {27'd0, rs_a}, {27'd0, vecs[i].rs});
            chk($sformatf("v%0d rt", i), {27'd0, rt_a}, {27'd0, vecs[i].rt});
            chk($sformatf("v%0d rd", i), {27'd0, rd_a}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d shamt", i), {27'd0, shamt_a}, {27'd0, vecs[i].shamt});
            chk($sformatf("v%0d funct", i), {26'd0, funct_a}, {26'd0, vecs[i].funct});
            chk($sformatf("v%0d imm_ext", i), imm_a, vecs[i].imm);
            chk($sformatf("v%0d jaddr", i), {6'd0, jaddr_a}, {6'd0, vecs[i].jaddr});
            chk($sformatf("v%0d ctl", i), {22'd0, ctl_a}, {22'd0, vecs[i].ctl});
            chk($sformatf("v%0d alu_op", i), {30'd0, alu_op_a}, {30'd0, vecs[i].alu});
            chk($sformatf("v%0d illegal", i), {31'd0, illegal_a}, 32'd0);
        end

        // bne accepted, then held through a 3-cycle downstream stall.
        instr = 32'h1422_0008; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("bne branch_ne", {31'd0, branch_ne_a}, 32'd1);
        instr = I_ADDI; out_ready = 1'b0;
        #1;
        chk("stall in_ready", {31'd0, in_ready_a}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d out_valid", k), {31'd0, out_valid_a}, 32'd1);
            chk($sformatf("stall%0d ctl", k), {22'd0, ctl_a}, {22'd0, 10'b0000011000});
            chk($sformatf("stall%0d imm_ext", k), imm_a, 32'h0000_0008);
            chk($sformatf("stall%0d rt", k), {27'd0, rt_a}, 32'd2);
            chk($sformatf("stall%0d in_ready", k), {31'd0, in_ready_a}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", {31'd0, in_ready_a}, 32'd1);
        tick();
        chk("replace out_valid", {31'd0, out_valid_a}, 32'd1);
        chk("replace ctl", {22'd0, ctl_a}, {22'd0, 10'b1000100000});
        chk("replace imm_ext", imm_a, 32'hFFFF_8000);
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", {31'd0, out_valid_a}, 32'd0);

        // Asynchronous reset discards a held bundle.
        instr = vecs[0].instr; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk("pre-rst out_valid", {31'd0, out_valid_a}, 32'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("async rst mem_read", {31'd0, mem_read_a}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post-rst no accept", {31'd0, out_valid_a}, 32'd0);

        // Five illegal opcodes; 2-bit counter saturates at 3.
        instr = I_BAD; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("ill%0d out_valid", k), {31'd0, out_valid_a}, 32'd1);
            chk($sformatf("ill%0d illegal", k), {31'd0, illegal_a}, 32'd1);
            chk($sformatf("ill%0d ctl", k), {22'd0, ctl_a}, 32'd0);
            chk($sformatf("ill%0d alu_op", k), {30'd0, alu_op_a}, 32'd0);
            chk($sformatf("ill%0d cnt", k), {30'd0, cnt_a}, (k < 3) ? k + 1 : 3);
        end
        in_valid = 1'b0;
        tick();
        chk("no-halt halted", {31'd0, halted_a}, 32'd0);
        chk("no-halt in_ready", {31'd0, in_ready_a}, 32'd1);

        // Halt on illegal: illegal delivered, following addi never accepted.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt pre in_ready", {31'd0, in_ready_h}, 32'd1);
        instr = I_BAD; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("halt out_valid", {31'd0, out_valid_h}, 32'd1);
        chk("halt illegal", {31'd0, illegal_h}, 32'd1);
        chk("halt halted", {31'd0, halted_h}, 32'd1);
        chk("halt in_ready", {31'd0, in_ready_h}, 32'd0);
        instr = I_ADDI;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("halt%0d out_valid", k), {31'd0, out_valid_h}, 32'd0);
            chk($sformatf("halt%0d in_ready", k), {31'd0, in_ready_h}, 32'd0);
            chk($sformatf("halt%0d alu_src", k), {31'd0, alu_src_h}, 32'd0);
        end
        chk("halt cnt", {24'd0, cnt_h}, 32'd1);
        chk("halt peer accepted addi", {31'd0, alu_src_a}, 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt rst in_ready", {31'd0, in_ready_h}, 32'd1);
        chk("halt rst halted", {31'd0, halted_h}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
